// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - load funct3 codes, FSM states and size/legality helpers
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RESP
    } state_e;

    // Byte count of a load; 0 marks an unrecognised code.
    function automatic logic [3:0] load_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU:  return 4'd1;
            F3_LH, F3_LHU:  return 4'd2;
            F3_LW, F3_LWU:  return 4'd4;
            F3_LD:          return 4'd8;
            default:        return 4'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] funct3, input int xlen);
        if (load_size(funct3) == 4'd0) begin
            return 1'b0;
        end
        if (funct3 == F3_LD || funct3 == F3_LWU) begin
            return xlen == 64;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - selects the addressed bytes from {hi,lo} and sign/zero-extends them
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]           data_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  logic [2:0]                  funct3_i,
    output logic [XLEN-1:0]             result_o
);

    logic [XLEN-1:0] low;
    logic            sign;
    int              nbits;

    always_comb begin
        low   = XLEN'(data_i >> {off_i, 3'b000});
        sign  = 1'b0;
        nbits = 0;
        case (funct3_i)
            F3_LB:  begin nbits = 8;  sign = low[7];  end
            F3_LH:  begin nbits = 16; sign = low[15]; end
            F3_LW:  begin nbits = 32; sign = low[31]; end
            F3_LBU: nbits = 8;
            F3_LHU: nbits = 16;
            F3_LWU: nbits = 32;
            F3_LD:  nbits = XLEN;
            default: nbits = 0;
        endcase
        // Bits above the loaded width take the sign bit (zero for unsigned loads).
        for (int i = 0; i < XLEN; i++) begin
            result_o[i] = (i < nbits) ? low[i] : sign;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - multi-cycle aligned-word load path; LOAD_MISALIGN_SPLIT_EN enables split reads
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    state_e            state_q, state_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [2*XLEN-1:0] ext_in;
    logic [XLEN-1:0]   ext_out;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic [XLEN-1:0]   lo_q, lo_d;
`endif

    function automatic logic crosses(input logic [OFFW-1:0] off, input logic [2:0] funct3);
        return (5'(off) + 5'(load_size(funct3))) > 5'(NBYTES);
    endfunction

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // The upper word is only live while the second read returns.
    always_comb begin
`ifdef LOAD_MISALIGN_SPLIT_EN
        ext_in = (state_q == ST_RD1) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
`else
        ext_in = {{XLEN{1'b0}}, mem_rdata};
`endif
    end

    load_extract #(.XLEN(XLEN)) u_extract (
        .data_i   (ext_in),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (ext_out)
    );

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        f3_d       = f3_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
        lo_d       = lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d = req_addr[OFFW-1:0];
                    f3_d  = req_funct3;
                    if (!is_legal(req_funct3, XLEN)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end
`ifndef LOAD_MISALIGN_SPLIT_EN
                    else if (crosses(req_addr[OFFW-1:0], req_funct3)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end
`endif
                    else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {req_addr[ADDR_W-1:OFFW], OFFW'(0)};
                        state_d    = ST_RD0;
                    end
                end
            end
            ST_RD0: begin
                if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    if (crosses(off_q, f3_q)) begin
                        lo_d       = mem_rdata;
                        mem_req_d  = 1'b1;
                        mem_addr_d = mem_addr_q + ADDR_W'(NBYTES);
                        state_d    = ST_RD1;
                    end else
`endif
                    begin
                        rsp_data_d = ext_out;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RD1: begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                if (mem_rvalid) begin
                    rsp_data_d = ext_out;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            f3_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            lo_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
            lo_q       <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed vector bench for load_align_unit (XLEN 32 and 64)
module tb_load_align_unit;
    import load_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, mem_req, mem_rvalid, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, mem_addr, mem_rdata, rsp_data;
    logic [2:0]  req_funct3;

    logic        req_valid64, req_ready64, mem_req64, mem_rvalid64, rsp_valid64, rsp_ready64, rsp_err64;
    logic [31:0] req_addr64, mem_addr64;
    logic [63:0] mem_rdata64, rsp_data64;
    logic [2:0]  req_funct3_64;

    load_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid64), .req_ready(req_ready64),
        .req_addr(req_addr64), .req_funct3(req_funct3_64), .mem_req(mem_req64),
        .mem_addr(mem_addr64), .mem_rvalid(mem_rvalid64), .mem_rdata(mem_rdata64),
        .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready64), .rsp_data(rsp_data64), .rsp_err(rsp_err64)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] rd32(input logic [31:0] a);
        case (a)
            32'h100: return 32'h8899AABB;
            32'h104: return 32'h11223344;
            default: return 32'h0;
        endcase
    endfunction

    // 32-bit memory with programmable read latency; every strobe is logged.
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr;
    logic [31:0] req_log[$];

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_req) begin
            req_log.push_back(mem_addr);
            if (mem_lat <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= rd32(mem_addr);
            end else begin
                pend_cnt  <= mem_lat - 1;
                pend_addr <= mem_addr;
            end
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= rd32(pend_addr);
            end
        end
    end

    always @(posedge clk) begin
        mem_rvalid64 <= mem_req64;
        mem_rdata64  <= (mem_addr64 == 32'h100) ? 64'h11223344_8899AABB : 64'h0;
    end

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                           output logic [31:0] d, output logic e, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_funct3 = f3;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_timeout", 64'(rsp_valid), 64'd1);
        d = rsp_data; e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_load64(input logic [31:0] a, input logic [2:0] f3,
                             output logic [63:0] d, output logic e);
        int lat;
        @(negedge clk);
        req_valid64 = 1'b1; req_addr64 = a; req_funct3_64 = f3;
        @(negedge clk);
        req_valid64 = 1'b0;
        lat = 1;
        while (!rsp_valid64 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp64_latency", 64'(lat), 64'd3);
        d = rsp_data64; e = rsp_err64;
        rsp_ready64 = 1'b1;
        @(negedge clk);
        rsp_ready64 = 1'b0;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nreq;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [63:0] data;
    } vec64_t;

    vec_t   vecs[$];
    vec64_t vecs64[$];

    initial begin
        logic [31:0] d;
        logic [63:0] d64;
        logic        e;
        int          lat, s, k;
        logic        stable, spurious;

        vecs.push_back('{"lb_101",  32'h101, F3_LB,  32'hFFFFFFAA, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{"lhu_102", 32'h102, F3_LHU, 32'h00008899, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{"lh_102",  32'h102, F3_LH,  32'hFFFF8899, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{"lw_104",  32'h104, F3_LW,  32'h11223344, 1'b0, 3, 1, 32'h104, 32'h0});
        vecs.push_back('{"lbu_100", 32'h100, F3_LBU, 32'h000000BB, 1'b0, 3, 1, 32'h100, 32'h0});
        vecs.push_back('{"lb_107",  32'h107, F3_LB,  32'h00000011, 1'b0, 3, 1, 32'h104, 32'h0});
        vecs.push_back('{"lhu_106", 32'h106, F3_LHU, 32'h00001122, 1'b0, 3, 1, 32'h104, 32'h0});
        vecs.push_back('{"ld_x32",  32'h100, F3_LD,  32'h0,        1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{"lwu_x32", 32'h100, F3_LWU, 32'h0,        1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{"f3_111",  32'h100, 3'b111, 32'h0,        1'b1, 1, 0, 32'h0,   32'h0});
`ifdef LOAD_MISALIGN_SPLIT_EN
        vecs.push_back('{"lw_103",  32'h103, F3_LW,  32'h22334488, 1'b0, 5, 2, 32'h100, 32'h104});
        vecs.push_back('{"lh_103",  32'h103, F3_LH,  32'h00004488, 1'b0, 5, 2, 32'h100, 32'h104});
`else
        vecs.push_back('{"lw_103",  32'h103, F3_LW,  32'h0,        1'b1, 1, 0, 32'h0,   32'h0});
        vecs.push_back('{"lh_103",  32'h103, F3_LH,  32'h0,        1'b1, 1, 0, 32'h0,   32'h0});
`endif
        vecs64.push_back('{32'h100, F3_LD,  64'h11223344_8899AABB});
        vecs64.push_back('{32'h104, F3_LW,  64'h00000000_11223344});
        vecs64.push_back('{32'h100, F3_LW,  64'hFFFFFFFF_8899AABB});
        vecs64.push_back('{32'h100, F3_LWU, 64'h00000000_8899AABB});

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_funct3 = '0; rsp_ready = 1'b0;
        req_valid64 = 1'b0; req_addr64 = '0; req_funct3_64 = '0; rsp_ready64 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            s = req_log.size();
            do_load(vecs[i].addr, vecs[i].f3, d, e, lat);
            check($sformatf("%s_data", vecs[i].nm), 64'(d), 64'(vecs[i].data));
            check($sformatf("%s_err",  vecs[i].nm), 64'(e), 64'(vecs[i].err));
            check($sformatf("%s_lat",  vecs[i].nm), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("%s_nreq", vecs[i].nm), 64'(req_log.size() - s), 64'(vecs[i].nreq));
            if (vecs[i].nreq > 0 && req_log.size() > s)
                check($sformatf("%s_addr0", vecs[i].nm), 64'(req_log[s]), 64'(vecs[i].a0));
            if (vecs[i].nreq > 1 && req_log.size() > s + 1)
                check($sformatf("%s_addr1", vecs[i].nm), 64'(req_log[s+1]), 64'(vecs[i].a1));
        end

        // Backpressure: response held for 5 cycles while a new request waits.
        s = req_log.size();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h100; req_funct3 = F3_LW;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        check("bp_first_valid", 64'(rsp_valid), 64'd1);
        req_valid = 1'b1; req_addr = 32'h104; req_funct3 = F3_LW;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 32'h8899AABB || req_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_hold_stable", 64'(stable), 64'd1);
        check("bp_hold_nreq", 64'(req_log.size() - s), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_ready", 64'(req_ready), 64'd1);
        check("bp_idle_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        check("bp_second_data", 64'(rsp_data), 64'h11223344);
        check("bp_total_nreq", 64'(req_log.size() - s), 64'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while RD0 waits on a slow memory; the late data must be dropped.
        mem_lat = 3;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h100; req_funct3 = F3_LB;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_mem_req",   64'(mem_req),   64'd0);
        check("mid_rst_mem_addr",  64'(mem_addr),  64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp_data",  64'(rsp_data),  64'd0);
        check("mid_rst_rsp_err",   64'(rsp_err),   64'd0);
        spurious = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) spurious = 1'b1;
        end
        check("mid_rst_no_rsp", 64'(spurious), 64'd0);
        mem_lat = 1;
        do_load(32'h100, F3_LBU, d, e, lat);
        check("post_rst_lbu_data", 64'(d), 64'h000000BB);
        check("post_rst_lbu_lat",  64'(lat), 64'd3);

        foreach (vecs64[i]) begin
            do_load64(vecs64[i].addr, vecs64[i].f3, d64, e);
            check($sformatf("x64_%0d_data", i), d64, vecs64[i].data);
            check($sformatf("x64_%0d_err", i), 64'(e), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
